// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the program loader.
//   state_e           - loader FSM states
//   INSTR_W/OPERAND_W - opcode/operand widths of one program word
//   WORD_W            - width of a staged word {instr, operand}
//   DEFAULT_MAX_WORDS - default program memory capacity in words
package prog_loader_pkg;

    localparam int unsigned INSTR_W           = 4;
    localparam int unsigned OPERAND_W         = 4;
    localparam int unsigned WORD_W            = INSTR_W + OPERAND_W;
    localparam int unsigned DEFAULT_MAX_WORDS = 16;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoad,
        StStart,
        StRun
    } state_e;

endpackage

// File: rtl/prog_fifo.sv
// prog_fifo: synchronous FIFO staging program words between the input stream
// and the processor write port.
//   clk, reset_n      - clock, synchronous active-low reset
//   i_flush           - empty the FIFO at the next edge
//   i_push/i_wdata    - write a word (ignored when full)
//   i_pop/o_rdata     - head word; i_pop removes it (ignored when empty)
//   o_full/o_empty    - occupancy flags
//   o_count           - number of stored words
module prog_fifo
    import prog_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WORD_W-1:0]        i_wdata,
    input  logic                     i_pop,
    output logic [WORD_W-1:0]        o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == (AW + 1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!reset_n || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
        end
    end

    // Storage needs no reset: contents are only observed through the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams a program into a processor's program memory through a
// small FIFO, then releases the processor.
//   clk, reset_n                  - clock, synchronous active-low reset
//   start                         - begin (or restart) a load session
//   hold                          - stall processor writes during LOAD
//   in_valid/in_ready             - input word handshake
//   in_instr/in_operand/in_last   - offered word and end-of-program marker
//   mem_write/instr/portin        - registered program-memory write port
//   PC_reset                      - processor PC reset (CLEAR and START)
//   busy/running                  - session in progress / program released
//   word_count                    - words written this session (saturating)
//   error                         - sticky overflow flag
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_WORDS  = DEFAULT_MAX_WORDS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 hold,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_W-1:0]   in_instr,
    input  logic [OPERAND_W-1:0] in_operand,
    input  logic                 in_last,
    output logic                 mem_write,
    output logic [INSTR_W-1:0]   instr,
    output logic [OPERAND_W-1:0] portin,
    output logic                 PC_reset,
    output logic                 busy,
    output logic                 running,
    output logic [4:0]           word_count,
    output logic                 error
);

    localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;

    state_e                r_state;
    state_e                w_state_d;
    logic                  r_mem_write;
    logic [INSTR_W-1:0]    r_instr;
    logic [OPERAND_W-1:0]  r_portin;
    logic [4:0]            r_word_count;
    logic                  r_error;
    logic                  r_last_accepted;
    logic                  r_done;

    logic                  w_full;
    logic                  w_empty;
    logic [FCW-1:0]        w_count;
    logic [WORD_W-1:0]     w_head;
    logic                  w_in_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_pop_last;
    logic                  w_at_max;
    logic                  w_overflow;
    logic                  w_flush;
    logic                  w_enter_clear;

    assign w_in_ready = (r_state == StLoad) && !w_full && !r_last_accepted;
    assign w_push     = in_valid && w_in_ready;
    assign w_at_max   = (r_word_count == 5'(MAX_WORDS));
    assign w_pop      = (r_state == StLoad) && !w_empty && !hold && !w_at_max && !r_done;
    // Once in_last is in the FIFO nothing else enters, so the final word is
    // the one popped when a single entry remains.
    assign w_pop_last = w_pop && r_last_accepted && (w_count == FCW'(1));
    assign w_overflow = (r_state == StLoad) && w_at_max && !r_done;
    assign w_flush    = (r_state == StClear) || w_overflow;
    assign w_enter_clear = (w_state_d == StClear);

    prog_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_wdata ({in_instr, in_operand}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_d = StClear;
            StClear: w_state_d = StLoad;
            StLoad: begin
                // r_done is set on the final pop, so START follows the last write.
                if (r_done) begin
                    w_state_d = StStart;
                end else if (w_overflow) begin
                    w_state_d = StIdle;
                end
            end
            StStart: w_state_d = StRun;
            StRun:   if (start) w_state_d = StClear;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state         <= StIdle;
            r_mem_write     <= 1'b0;
            r_instr         <= '0;
            r_portin        <= '0;
            r_word_count    <= '0;
            r_error         <= 1'b0;
            r_last_accepted <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_mem_write <= w_pop;
            if (w_pop) begin
                r_instr  <= w_head[WORD_W-1:OPERAND_W];
                r_portin <= w_head[OPERAND_W-1:0];
            end
            if (w_enter_clear) begin
                r_word_count    <= '0;
                r_error         <= 1'b0;
                r_last_accepted <= 1'b0;
                r_done          <= 1'b0;
            end else begin
                if (w_pop) begin
                    r_word_count <= r_word_count + 5'd1;
                end
                if (w_overflow) begin
                    r_error <= 1'b1;
                end
                if (w_push && in_last) begin
                    r_last_accepted <= 1'b1;
                end
                if (w_pop_last) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign mem_write  = r_mem_write;
    assign instr      = r_instr;
    assign portin     = r_portin;
    assign word_count = r_word_count;
    assign error      = r_error;
    assign PC_reset   = (r_state == StClear) || (r_state == StStart);
    assign busy       = (r_state == StClear) || (r_state == StLoad) || (r_state == StStart);
    assign running    = (r_state == StRun);

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       hold;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_instr;
    logic [3:0] in_operand;
    logic       in_last;
    logic       mem_write;
    logic [3:0] instr;
    logic [3:0] portin;
    logic       PC_reset;
    logic       busy;
    logic       running;
    logic [4:0] word_count;
    logic       error;

    int n_pass  = 0;
    int n_total = 0;

    // Cumulative monitor records, written only by the monitor process.
    int         pc_cnt = 0;
    logic [7:0] wq[$];

    logic [7:0] prog [9] = '{8'h63, 8'h40, 8'h63, 8'h41, 8'h50, 8'h80, 8'h51, 8'h00, 8'h70};

    always #5 clk = ~clk;

    prog_loader #(
        .FIFO_DEPTH (4),
        .MAX_WORDS  (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .hold       (hold),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_operand (in_operand),
        .in_last    (in_last),
        .mem_write  (mem_write),
        .instr      (instr),
        .portin     (portin),
        .PC_reset   (PC_reset),
        .busy       (busy),
        .running    (running),
        .word_count (word_count),
        .error      (error)
    );

    always @(negedge clk) begin
        if (mem_write === 1'b1) wq.push_back({instr, portin});
        if (PC_reset === 1'b1) pc_cnt++;
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic last, output bit ok);
        in_valid   = 1'b1;
        in_instr   = w[7:4];
        in_operand = w[3:0];
        in_last    = last;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) ok = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_running(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(posedge clk); #1;
            if (running === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic send_prog(output int n_lost);
        bit ok;
        n_lost = 0;
        for (int i = 0; i < 9; i++) begin
            send_word(prog[i], (i == 8), ok);
            if (!ok) n_lost++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; hold = 1'b0; in_valid = 1'b0;
        in_instr = '0; in_operand = '0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({mem_write, PC_reset, in_ready, busy, running, error, instr, portin, word_count} !== '0)
            $display("FAIL reset_outputs got %b want all zero",
                     {mem_write, PC_reset, in_ready, busy, running, error, instr, portin, word_count});
        else n_pass++;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({busy, in_ready, PC_reset} !== 3'b000)
            $display("FAIL idle_after_reset got %b want 000", {busy, in_ready, PC_reset});
        else n_pass++;
    endtask

    task automatic test_program();
        bit ok;
        int pc0 = pc_cnt;
        int b   = wq.size();
        int lost = 0;
        do_start();
        n_total++;
        if ({PC_reset, busy, word_count} !== {1'b1, 1'b1, 5'd0})
            $display("FAIL clear_state got PC_reset=%b busy=%b wc=%0d want 1 1 0",
                     PC_reset, busy, word_count);
        else n_pass++;
        // First word: no write yet in the cycle after acceptance.
        send_word(prog[0], 1'b0, ok);
        if (!ok) lost++;
        n_total++;
        if (mem_write !== 1'b0) $display("FAIL latency_stage got mem_write=%b want 0", mem_write);
        else n_pass++;
        send_word(prog[1], 1'b0, ok);
        if (!ok) lost++;
        n_total++;
        if ({mem_write, instr, portin} !== {1'b1, prog[0]})
            $display("FAIL latency_write got %b_%h want 1_%h", mem_write, {instr, portin}, prog[0]);
        else n_pass++;
        for (int i = 2; i < 9; i++) begin
            send_word(prog[i], (i == 8), ok);
            if (!ok) lost++;
        end
        wait_running(ok);
        n_total++;
        if (!ok || lost != 0) $display("FAIL prog_complete got running=%b lost=%0d want 1 0",
                                        running, lost);
        else n_pass++;
        n_total++;
        if (wq.size() - b !== 9) $display("FAIL prog_write_count got %0d want 9", wq.size() - b);
        else n_pass++;
        for (int i = 0; i < 9 && b + i < wq.size(); i++) begin
            n_total++;
            if (wq[b+i] !== prog[i]) $display("FAIL prog_word%0d got %h want %h", i, wq[b+i], prog[i]);
            else n_pass++;
        end
        n_total++;
        if (pc_cnt - pc0 !== 2) $display("FAIL prog_pc_pulses got %0d want 2", pc_cnt - pc0);
        else n_pass++;
        n_total++;
        if ({word_count, busy, in_ready} !== {5'd9, 1'b0, 1'b0})
            $display("FAIL prog_run_state got wc=%0d busy=%b rdy=%b want 9 0 0",
                     word_count, busy, in_ready);
        else n_pass++;
    endtask

    task automatic test_hold();
        bit ok;
        int b = wq.size();
        int lost = 0;
        int wr_seen = 0;
        hold = 1'b1;
        do_start();
        for (int i = 0; i < 4; i++) begin
            send_word(prog[i], 1'b0, ok);
            if (!ok) lost++;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (mem_write === 1'b1) wr_seen++;
            n_total++;
            if (in_ready !== 1'b0) $display("FAIL hold_full_ready got %b want 0", in_ready);
            else n_pass++;
            @(posedge clk); #1;
        end
        n_total++;
        if (wr_seen != 0 || wq.size() != b || lost != 0)
            $display("FAIL hold_no_write got writes=%0d lost=%0d want 0 0", wq.size() - b, lost);
        else n_pass++;
        hold = 1'b0;
        for (int i = 4; i < 9; i++) begin
            send_word(prog[i], (i == 8), ok);
            if (!ok) lost++;
        end
        wait_running(ok);
        n_total++;
        if (!ok || lost != 0 || wq.size() - b !== 9)
            $display("FAIL hold_drain got running=%b lost=%0d writes=%0d want 1 0 9",
                     running, lost, wq.size() - b);
        else n_pass++;
        for (int i = 0; i < 9 && b + i < wq.size(); i++) begin
            n_total++;
            if (wq[b+i] !== prog[i]) $display("FAIL hold_word%0d got %h want %h", i, wq[b+i], prog[i]);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int pc0 = pc_cnt;
        int b = wq.size();
        do_start();
        for (int i = 0; i < 17; i++) send_word(8'(i), 1'b0, ok);
        repeat (4) @(posedge clk);
        #1;
        n_total++;
        if (wq.size() - b !== 16) $display("FAIL ovf_writes got %0d want 16", wq.size() - b);
        else n_pass++;
        n_total++;
        if (wq.size() - b == 16 && (wq[b] !== 8'h00 || wq[b+15] !== 8'h0f))
            $display("FAIL ovf_words got %h,%h want 00,0f", wq[b], wq[b+15]);
        else n_pass++;
        n_total++;
        if ({error, busy, running, in_ready, word_count} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd16})
            $display("FAIL ovf_state got err=%b busy=%b run=%b rdy=%b wc=%0d want 1 0 0 0 16",
                     error, busy, running, in_ready, word_count);
        else n_pass++;
        n_total++;
        if (pc_cnt - pc0 !== 1) $display("FAIL ovf_pc_pulses got %0d want 1", pc_cnt - pc0);
        else n_pass++;
        do_start();
        n_total++;
        if ({error, PC_reset, word_count} !== {1'b0, 1'b1, 5'd0})
            $display("FAIL ovf_restart got err=%b PC_reset=%b wc=%0d want 0 1 0",
                     error, PC_reset, word_count);
        else n_pass++;
        send_word(8'h70, 1'b1, ok);
        wait_running(ok);
        n_total++;
        if (!ok || word_count !== 5'd1) $display("FAIL ovf_recover got running=%b wc=%0d want 1 1",
                                                running, word_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int pc0 = pc_cnt;
        int b = wq.size();
        int lost;
        do_start();
        for (int i = 0; i < 4; i++) send_word(prog[i], 1'b0, ok);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if ({mem_write, PC_reset, in_ready, busy, running, error, instr, portin, word_count} !== '0)
            $display("FAIL midreset_outputs got %b want all zero",
                     {mem_write, PC_reset, in_ready, busy, running, error, instr, portin, word_count});
        else n_pass++;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (wq.size() - b !== 3 || pc_cnt - pc0 !== 1)
            $display("FAIL midreset_abandon got writes=%0d pcs=%0d want 3 1",
                     wq.size() - b, pc_cnt - pc0);
        else n_pass++;
        b = wq.size();
        do_start();
        send_prog(lost);
        wait_running(ok);
        n_total++;
        if (!ok || lost != 0 || wq.size() - b !== 9 || word_count !== 5'd9)
            $display("FAIL midreset_reload got run=%b lost=%0d writes=%0d wc=%0d want 1 0 9 9",
                     running, lost, wq.size() - b, word_count);
        else n_pass++;
        n_total++;
        if (wq.size() - b == 9 && (wq[b] !== prog[0] || wq[b+8] !== prog[8]))
            $display("FAIL midreset_words got %h,%h want %h,%h", wq[b], wq[b+8], prog[0], prog[8]);
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        bit ok;
        int pc0 = pc_cnt;
        int b = wq.size();
        int lost = 0;
        do_start();
        for (int i = 0; i < 9; i++) begin
            start = (i == 2);
            send_word(prog[i], (i == 8), ok);
            start = 1'b0;
            if (!ok) lost++;
        end
        wait_running(ok);
        n_total++;
        if (!ok || lost != 0 || wq.size() - b !== 9 || pc_cnt - pc0 !== 2)
            $display("FAIL start_in_load got run=%b lost=%0d writes=%0d pcs=%0d want 1 0 9 2",
                     running, lost, wq.size() - b, pc_cnt - pc0);
        else n_pass++;
        do_start();
        n_total++;
        if ({PC_reset, word_count, busy, running} !== {1'b1, 5'd0, 1'b1, 1'b0})
            $display("FAIL start_in_run got PC_reset=%b wc=%0d busy=%b run=%b want 1 0 1 0",
                     PC_reset, word_count, busy, running);
        else n_pass++;
        send_word(8'h63, 1'b0, ok);
        send_word(8'h70, 1'b1, ok);
        wait_running(ok);
        n_total++;
        if (!ok || word_count !== 5'd2) $display("FAIL reload_done got run=%b wc=%0d want 1 2",
                                                running, word_count);
        else n_pass++;
    endtask

    task automatic test_extra_after_last();
        bit ok;
        int b = wq.size();
        int rdy_seen = 0;
        do_start();
        send_word(8'h12, 1'b0, ok);
        send_word(8'h34, 1'b0, ok);
        send_word(8'h56, 1'b1, ok);
        in_valid = 1'b1; in_instr = 4'h9; in_operand = 4'h9;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0) rdy_seen++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_running(ok);
        n_total++;
        if (rdy_seen !== 0) $display("FAIL extra_ready got %0d ready cycles want 0", rdy_seen);
        else n_pass++;
        n_total++;
        if (!ok || word_count !== 5'd3 || wq.size() - b !== 3)
            $display("FAIL extra_count got run=%b wc=%0d writes=%0d want 1 3 3",
                     running, word_count, wq.size() - b);
        else n_pass++;
        n_total++;
        if (wq.size() - b == 3 && wq[b+2] !== 8'h56)
            $display("FAIL extra_last_word got %h want 56", wq[b+2]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_program();
        test_hold();
        test_overflow();
        test_reset_mid();
        test_start_ignored();
        test_extra_after_last();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, number of staged program words (power of two, at least 2).
REQ-002 Parameter: MAX_WORDS, default 16, program memory capacity in words.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  one-cycle request to begin a load session.
REQ-006 hold  in  1  pause writes to the processor while high.
REQ-007 in_valid  in  1  a program word is offered.
REQ-008 in_ready  out  1  the loader accepts the offered word this cycle.
REQ-009 in_instr  in  4  opcode of the offered word.
REQ-010 in_operand  in  4  operand of the offered word.
REQ-011 in_last  in  1  the offered word is the final word of the program.
REQ-012 mem_write  out  1  processor program-memory write strobe.
REQ-013 instr  out  4  opcode to the processor, valid while mem_write is 1.
REQ-014 portin  out  4  operand to the processor, valid while mem_write is 1.
REQ-015 PC_reset  out  1  processor program-counter reset, active-high.
REQ-016 busy  out  1  a load session is in progress.
REQ-017 running  out  1  the program is loaded and the processor has been released.
REQ-018 word_count  out  5  number of words written in the current session.
REQ-019 error  out  1  program overflow flag, sticky.

Function
REQ-020 The FSM SHALL have the states IDLE, CLEAR, LOAD, START and RUN.
REQ-021 IDLE: in_ready=0; start=1 -> CLEAR.
REQ-022 CLEAR: PC_reset=1 for exactly one cycle; word_count, error and the FIFO are cleared; next state LOAD.
REQ-023 LOAD: in_ready = !fifo_full && !last_accepted; a word is pushed on in_valid && in_ready.
REQ-024 LOAD: each cycle with FIFO non-empty and hold=0, the head word is popped into registered outputs. mem_write=1 for that single cycle, instr/portin carry the word, and word_count increments.
REQ-025 Latency: a word accepted at edge k into an empty FIFO appears on mem_write/instr/portin in the cycle after edge k+1 (one staging cycle).
REQ-026 A push and a pop in the same cycle SHALL both take effect; there is no bypass when the FIFO is full.
REQ-027 After acceptance of the in_last word, in_ready=0 until the session ends; later in_valid is ignored.
REQ-028 When the in_last word is written -> START. START: PC_reset=1, mem_write=0 for one cycle -> RUN.
REQ-029 RUN: running=1, busy=0; start=1 -> CLEAR (reload); in_ready=0.
REQ-030 Overflow: if MAX_WORDS words have been written without in_last, the loader SHALL set error=1, flush the FIFO and return to IDLE without pulsing PC_reset; in_last on word MAX_WORDS is legal.
REQ-031 start SHALL be ignored in CLEAR, LOAD and START.
REQ-032 busy=1 in CLEAR, LOAD and START.
REQ-033 hold in states other than LOAD has no effect.
REQ-034 word_count saturates at MAX_WORDS and holds its value in RUN and IDLE until the next CLEAR.

Reset
REQ-035 While reset_n=0 at an edge: state=IDLE; FIFO empty; outputs mem_write, PC_reset, in_ready, busy, running and error = 0; instr=0, portin=0, word_count=0.
REQ-036 Reset mid-session SHALL abandon the load immediately, with no further mem_write or PC_reset pulse.

Structure
REQ-037 Package prog_loader_pkg SHALL hold the FSM state enum, the word-width constants (opcode 4, operand 4) and the default MAX_WORDS.
REQ-038 A sub-module prog_fifo SHALL implement the synchronous FIFO: parameterised depth, 8-bit word {instr, operand}, full/empty flags, synchronous active-low reset.

Verification
REQ-039 Nine-word program (0110,0011)(0100,0000)(0110,0011)(0100,0001)(0101,0000)(1000,0000)(0101,0001)(0000,0000)(0111,0000,last), streamed back-to-back -> one PC_reset pulse, nine mem_write cycles with exact values in order, one PC_reset pulse, running=1, word_count=9.
REQ-040 hold=1 for 6 cycles while streaming -> FIFO fills, in_ready=0 after 4 accepted words, no mem_write; on release, words are drained in order with no loss.
REQ-041 Seventeen words with no in_last -> 16 writes, error=1, state IDLE, no final PC_reset; the next start clears error.
REQ-042 reset_n=0 after 3 of 9 words are written -> all outputs zero the next cycle; after a new start the full program reloads correctly.
REQ-043 start pulsed during LOAD -> ignored; start pulsed in RUN -> PC_reset pulse, word_count=0, new session begins.
REQ-044 in_valid held with extra words after the in_last word -> not accepted (in_ready=0), and word_count equals the program length.
